// File: rtl/md_unit_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the busy-sequencer state type.
package md_unit_e_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: computes the 64-bit result at start, then
// holds it in temp registers until a fixed busy period ends and commits it.
module md_unit_e
    import md_unit_e_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        md_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              e_valid,
    output logic              busy,
    output logic              md_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] md_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tmp_hi_q, tmp_hi_d;
    logic [DATA_W-1:0] tmp_lo_q, tmp_lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              skip_q, skip_d;
    logic              start_prev_q;

    logic                     is_mult_c, is_div_c, is_md_c, start_c;
    logic signed [DATA_W-1:0] a_s, b_s;
    logic signed [63:0]       a_sx, b_sx, prod_s;
    logic [63:0]              prod_u;
    logic [DATA_W-1:0]        res_hi_c, res_lo_c;

    assign is_mult_c = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div_c  = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign is_md_c   = (md_op >= MD_MULT) && (md_op <= MD_MFLO);
    assign busy      = (state_q == ST_BUSY);
    assign start_c   = e_valid && !busy && (is_mult_c || is_div_c);
    assign md_stall  = e_valid && is_md_c && (busy || start_prev_q);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Full-width products; operands extended to 64 bits before the multiply
    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Result selected at start; divide-by-zero yields 0 here and is skipped at commit
    always_comb begin
        res_hi_c = '0;
        res_lo_c = '0;
        case (md_op)
            MD_MULT:  {res_hi_c, res_lo_c} = prod_s;
            MD_MULTU: {res_hi_c, res_lo_c} = prod_u;
            MD_DIV: begin
                if (b != '0) begin
                    res_lo_c = a_s / b_s;
                    res_hi_c = a_s % b_s;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    res_lo_c = a / b;
                    res_hi_c = a % b;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        md_out = '0;
        if (md_op == MD_MFHI)      md_out = hi_q;
        else if (md_op == MD_MFLO) md_out = lo_q;
    end

    // Next-state: start a busy period, run the countdown, commit on cnt==0
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        skip_d   = skip_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d  = ST_BUSY;
                    cnt_d    = is_mult_c ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    tmp_hi_d = res_hi_c;
                    tmp_lo_d = res_lo_c;
                    skip_d   = is_div_c && (b == '0);
                end else if (e_valid && (md_op == MD_MTHI)) begin
                    hi_d = a;
                end else if (e_valid && (md_op == MD_MTLO)) begin
                    lo_d = a;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!skip_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmp_hi_q     <= '0;
            tmp_lo_q     <= '0;
            skip_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmp_hi_q     <= tmp_hi_d;
            tmp_lo_q     <= tmp_lo_d;
            skip_q       <= skip_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            start_prev_q <= start_c;
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// Self-checking bench for md_unit_e: directed cases plus random ops checked
// against an arithmetic HI/LO model.
module tb_md_unit_e;
    import md_unit_e_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] a, b;
    logic        e_valid;
    logic        busy, md_stall;
    logic [31:0] hi, lo, md_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    md_unit_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b), .e_valid(e_valid),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic ev);
        md_op = op; a = x; b = y; e_valid = ev;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Architectural effect of a multi-cycle op on HI/LO
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint p, q, r;
        longint unsigned pu;
        case (op)
            MD_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                h = 32'(p >>> 32); l = 32'(p);
            end
            MD_MULTU: begin
                pu = 64'(x) * 64'(y);
                h = 32'(pu >> 32); l = 32'(pu);
            end
            MD_DIV: if (y != 0) begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                l = 32'(q); h = 32'(r);
            end
            MD_DIVU: if (y != 0) begin
                l = x / y; h = x % y;
            end
            default: ;
        endcase
    endfunction

    // Issue a multi-cycle op, present nxt behind it, check busy length, stall and commit
    task automatic run_arith(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                             input logic [3:0] nxt);
        int n;
        int cyc = 0;
        logic [31:0] eh, el;
        n = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
        eh = hi_m; el = lo_m;
        model(op, x, y, eh, el);
        drive(op, x, y, 1'b1); #1;
        chk("start_busy", 32'(busy), 32'd0);
        chk("start_stall", 32'(md_stall), 32'd0);
        tick();
        drive(nxt, $urandom, $urandom, 1'b1); #1;
        while (busy === 1'b1 && cyc < 60) begin
            chk("busy_stall", 32'(md_stall), 32'(nxt != MD_NONE));
            chk("busy_hi_hold", hi, hi_m);
            cyc++;
            tick(); #1;
        end
        chk("busy_len", 32'(cyc), 32'(n));
        hi_m = eh; lo_m = el;
        chk("commit_hi", hi, hi_m);
        chk("commit_lo", lo, lo_m);
        chk("commit_stall", 32'(md_stall), 32'd0);
        if (nxt == MD_MFHI) chk("mfhi_out", md_out, hi_m);
        if (nxt == MD_MFLO) chk("mflo_out", md_out, lo_m);
    endtask

    // MTHI/MTLO followed by the matching MF read
    task automatic run_mt(input logic [3:0] op, input logic [31:0] x);
        drive(op, x, $urandom, 1'b1); #1;
        chk("mt_stall", 32'(md_stall), 32'd0);
        tick();
        if (op == MD_MTHI) hi_m = x; else lo_m = x;
        drive((op == MD_MTHI) ? MD_MFHI : MD_MFLO, $urandom, $urandom, 1'b1); #1;
        chk("mt_busy", 32'(busy), 32'd0);
        chk("mf_stall", 32'(md_stall), 32'd0);
        chk("mf_out", md_out, (op == MD_MTHI) ? hi_m : lo_m);
        chk("mt_hi", hi, hi_m);
        chk("mt_lo", lo, lo_m);
    endtask

    initial begin
        logic [3:0]  ops [6];
        logic [3:0]  op;
        logic [31:0] x, y;
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

        reset = 1'b1;
        drive(MD_NONE, '0, '0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        drive(MD_MFHI, '0, '0, 1'b1); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        chk("rst_mdout", md_out, 32'd0);

        run_arith(MD_MULT, -32'sd3, 32'd7, MD_MFLO);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFEB);
        chk("t1_mdout", md_out, 32'hFFFF_FFEB);

        run_arith(MD_DIV, -32'sd7, 32'd2, MD_NONE);
        chk("t2_div_lo", lo, 32'hFFFF_FFFD);
        chk("t2_div_hi", hi, 32'hFFFF_FFFF);
        run_arith(MD_DIVU, -32'sd7, 32'd2, MD_MFHI);
        chk("t2_divu_lo", lo, 32'h7FFF_FFFC);
        chk("t2_divu_hi", hi, 32'd1);

        run_mt(MD_MTHI, 32'h1234);
        chk("t3_hi", hi, 32'h1234);

        run_mt(MD_MTHI, 32'd5);
        run_mt(MD_MTLO, 32'd9);
        run_arith(MD_DIV, 32'd77, 32'd0, MD_MFLO);
        chk("t4_hi", hi, 32'd5);
        chk("t4_lo", lo, 32'd9);

        run_arith(MD_MULTU, 32'hFFFF_FFFF, 32'd2, MD_MULTU);
        chk("t6_hi", hi, 32'd1);
        chk("t6_lo", lo, 32'hFFFF_FFFE);
        run_arith(MD_MULTU, 32'h0001_0000, 32'h0003_0000, MD_MFHI);

        // Flushed ops neither start nor write HI/LO
        drive(MD_MULT, 32'd5, 32'd6, 1'b0); #1;
        chk("flush_stall", 32'(md_stall), 32'd0);
        tick();
        chk("flush_busy", 32'(busy), 32'd0);
        drive(MD_MTHI, 32'd99, 32'd0, 1'b0);
        tick();
        chk("flush_hi", hi, hi_m);
        drive(MD_NONE, 32'd1, 32'd2, 1'b1); #1;
        chk("none_stall", 32'(md_stall), 32'd0);
        tick();
        chk("none_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(0, 5)];
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : 32'($urandom);
            if (op == MD_MTHI || op == MD_MTLO) run_mt(op, x);
            else run_arith(op, x, y, (i % 2 == 0) ? MD_MFHI : MD_MFLO);
        end

        // Reset during an op abandons it
        drive(MD_MULT, 32'd3, 32'd5, 1'b1);
        tick();
        drive(MD_NONE, '0, '0, 1'b1); #1;
        chk("t5_busy1", 32'(busy), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        hi_m = '0; lo_m = '0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_hi", hi, 32'd0);
        chk("t5_lo", lo, 32'd0);
        chk("t5_stall", 32'(md_stall), 32'd0);
        repeat (8) tick();
        chk("t5_hi_late", hi, hi_m);
        chk("t5_lo_late", lo, lo_m);
        chk("t5_busy_late", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
